// File: rtl/tx_gate_ctrl_list.sv
// rtl/tx_gate_ctrl_list.sv - time-aware gate control list executor for one TX port
//
// Purpose:
//   Steps through a programmable list of {gate bitmap, interval} entries and
//   drives the per-priority gate vector consumed by the TX QoS scheduler.
//   A cycle-start pulse from the time-sync logic starts or resyncs the list
//   at entry 0. While not running, the admin gate vector is driven instead.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_gate_enable         level: 1 runs the list, 0 forces the admin state
//   i_admin_gate_state    gate vector driven while not running
//   i_gcl_len             number of valid entries (1..GCL_DEPTH)
//   i_cycle_start         single-cycle pulse, (re)starts the list at entry 0
//   i_gcl_wr_*            table write port (strobe, index, gate, interval)
//   o_ControlList_state   registered gate vector, bit n=1 opens queue n
//   o_gcl_index           registered index of the active entry
//   o_gcl_running         high while executing the list
//   o_cycle_wrap          one-cycle pulse when the list wraps to entry 0
//   o_cfg_err             enabled with an out-of-range list length
module tx_gate_ctrl_list #(
  parameter int PORT_FIFO_PRI_NUM = 8,
  parameter int GCL_DEPTH         = 16,
  parameter int GCL_ADDR_W        = 4,
  parameter int INTERVAL_W        = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_gate_enable,
  input  logic [PORT_FIFO_PRI_NUM-1:0] i_admin_gate_state,
  input  logic [GCL_ADDR_W:0]          i_gcl_len,
  input  logic                         i_cycle_start,
  input  logic                         i_gcl_wr_en,
  input  logic [GCL_ADDR_W-1:0]        i_gcl_wr_addr,
  input  logic [PORT_FIFO_PRI_NUM-1:0] i_gcl_wr_gate,
  input  logic [INTERVAL_W-1:0]        i_gcl_wr_interval,
  output logic [PORT_FIFO_PRI_NUM-1:0] o_ControlList_state,
  output logic [GCL_ADDR_W-1:0]        o_gcl_index,
  output logic                         o_gcl_running,
  output logic                         o_cycle_wrap,
  output logic                         o_cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [GCL_ADDR_W:0]   LEN_MAX  = (GCL_ADDR_W+1)'(GCL_DEPTH);
  localparam logic [GCL_ADDR_W:0]   LEN_ONE  = (GCL_ADDR_W+1)'(1);
  localparam logic [GCL_ADDR_W-1:0] IDX_ONE  = GCL_ADDR_W'(1);
  localparam logic [INTERVAL_W-1:0] INTV_ONE = INTERVAL_W'(1);

  // Gate control table
  logic [PORT_FIFO_PRI_NUM-1:0] gate_mem_q [GCL_DEPTH];
  logic [INTERVAL_W-1:0]        intv_mem_q [GCL_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_gcl_wr_en) begin
      gate_mem_q[i_gcl_wr_addr] <= i_gcl_wr_gate;
      intv_mem_q[i_gcl_wr_addr] <= i_gcl_wr_interval;
    end
  end

  // Execution state
  state_e                       state_q, state_d;
  logic [PORT_FIFO_PRI_NUM-1:0] gate_q, gate_d;
  logic [GCL_ADDR_W-1:0]        idx_q, idx_d;
  logic [INTERVAL_W-1:0]        cnt_q, cnt_d;
  logic                         running_q, running_d;
  logic                         wrap_q, wrap_d;
  logic                         cfg_err_q, cfg_err_d;

  logic                         len_valid;
  logic                         last_entry;
  logic [GCL_ADDR_W-1:0]        load_idx;
  logic [PORT_FIFO_PRI_NUM-1:0] load_gate;
  logic [INTERVAL_W-1:0]        load_intv;
  logic [INTERVAL_W-1:0]        load_cnt;
  logic                         do_load;

  assign len_valid  = (i_gcl_len >= LEN_ONE) && (i_gcl_len <= LEN_MAX);
  // Extended compare so a length that shrank below index+1 also wraps.
  assign last_entry = (({1'b0, idx_q} + LEN_ONE) >= i_gcl_len);

  // Entry to load this cycle: only a plain advance goes to idx+1; a start,
  // a wrap or the first load from WAIT all go to entry 0.
  always_comb begin
    load_idx = '0;
    if ((state_q == ST_RUN) && !i_cycle_start && !last_entry) begin
      load_idx = idx_q + IDX_ONE;
    end
  end

  // Table is read from the registered contents, so a write landing on the
  // same edge as the load is seen only on the next visit to that entry.
  assign load_gate = gate_mem_q[load_idx];
  assign load_intv = intv_mem_q[load_idx];
  // Counter holds remaining cycles minus one; interval 0 behaves like 1.
  assign load_cnt  = (load_intv == '0) ? '0 : (load_intv - INTV_ONE);

  always_comb begin
    state_d   = state_q;
    gate_d    = gate_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    running_d = running_q;
    wrap_d    = 1'b0;
    do_load   = 1'b0;
    cfg_err_d = i_gate_enable && !len_valid;

    case (state_q)
      ST_IDLE: begin
        gate_d    = i_admin_gate_state;
        idx_d     = '0;
        cnt_d     = '0;
        running_d = 1'b0;
        if (i_gate_enable) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        gate_d    = i_admin_gate_state;
        idx_d     = '0;
        cnt_d     = '0;
        running_d = 1'b0;
        if (i_cycle_start && len_valid) begin
          state_d   = ST_RUN;
          running_d = 1'b1;
          do_load   = 1'b1;
        end
      end

      ST_RUN: begin
        if (!len_valid) begin
          state_d   = ST_WAIT;
          gate_d    = i_admin_gate_state;
          idx_d     = '0;
          cnt_d     = '0;
          running_d = 1'b0;
        end else if (i_cycle_start) begin
          // Resync abandons the current entry without a wrap pulse.
          do_load = 1'b1;
        end else if (cnt_q == '0) begin
          do_load = 1'b1;
          wrap_d  = last_entry;
        end else begin
          cnt_d = cnt_q - INTV_ONE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        gate_d    = i_admin_gate_state;
        idx_d     = '0;
        cnt_d     = '0;
        running_d = 1'b0;
      end
    endcase

    if (do_load) begin
      gate_d = load_gate;
      cnt_d  = load_cnt;
      idx_d  = load_idx;
    end

    // Disable overrides everything else.
    if (!i_gate_enable) begin
      state_d   = ST_IDLE;
      gate_d    = i_admin_gate_state;
      idx_d     = '0;
      cnt_d     = '0;
      running_d = 1'b0;
      wrap_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      gate_q    <= '1;
      idx_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign o_ControlList_state = gate_q;
  assign o_gcl_index         = idx_q;
  assign o_gcl_running       = running_q;
  assign o_cycle_wrap        = wrap_q;
  assign o_cfg_err           = cfg_err_q;

endmodule

// File: tb/tb_tx_gate_ctrl_list.sv
// tb/tb_tx_gate_ctrl_list.sv - self-checking bench for tx_gate_ctrl_list
module tb_tx_gate_ctrl_list;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  always #2 clk = ~clk;

  logic        rst;
  logic        en;
  logic [7:0]  admin;
  logic [4:0]  len;
  logic        start;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_gate;
  logic [31:0] wr_intv;
  logic [7:0]  st;
  logic [3:0]  idx;
  logic        running;
  logic        wrap;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_gate [DEPTH];
  int         m_intv [DEPTH];

  tx_gate_ctrl_list dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_gate_enable       (en),
    .i_admin_gate_state  (admin),
    .i_gcl_len           (len),
    .i_cycle_start       (start),
    .i_gcl_wr_en         (wr_en),
    .i_gcl_wr_addr       (wr_addr),
    .i_gcl_wr_gate       (wr_gate),
    .i_gcl_wr_interval   (wr_intv),
    .o_ControlList_state (st),
    .o_gcl_index         (idx),
    .o_gcl_running       (running),
    .o_cycle_wrap        (wrap),
    .o_cfg_err           (cfg_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [7:0] g, input int iv);
    wr_en   = 1'b1;
    wr_addr = a[3:0];
    wr_gate = g;
    wr_intv = 32'(iv);
    tick();
    wr_en   = 1'b0;
    m_gate[a] = g;
    m_intv[a] = iv;
  endtask

  function automatic int dur(input int k);
    return (m_intv[k] == 0) ? 1 : m_intv[k];
  endfunction

  // Schedule model: e cycles after the start edge, which entry is shown and
  // whether this cycle is the start of a new lap.
  function automatic void ref_pos(input int e, input int n, output int k, output bit w);
    int lap;
    int r;
    lap = 0;
    for (int j = 0; j < n; j++) lap += dur(j);
    r = e % lap;
    k = 0;
    while (r >= dur(k)) begin
      r -= dur(k);
      k++;
    end
    w = (e > 0) && ((e % lap) == 0);
  endfunction

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; admin = 8'h0F; len = 5'd1; start = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_gate = '0; wr_intv = '0;
    tick(); tick();
    checks++;
    if ({st, idx, running, wrap, cfg_err} !== {8'hFF, 4'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got st=%h idx=%0d run=%b wrap=%b err=%b want st=ff idx=0 run=0 wrap=0 err=0",
               st, idx, running, wrap, cfg_err);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (st !== 8'h0F) begin
      errors++;
      $display("FAIL reset_release_admin got %h want 0f", st);
    end
  endtask

  task automatic test_basic_run;
    int k;
    bit w;
    do_write(0, 8'h01, 5);
    do_write(1, 8'h82, 3);
    do_write(2, 8'hFF, 1);
    len = 5'd3; en = 1'b1;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int e = 0; e < 24; e++) begin
      ref_pos(e, 3, k, w);
      checks++;
      if ({st, idx, wrap, running} !== {m_gate[k], 4'(k), w, 1'b1}) begin
        errors++;
        $display("FAIL basic_run e=%0d got st=%h idx=%0d wrap=%b run=%b want st=%h idx=%0d wrap=%b run=1",
                 e, st, idx, wrap, running, m_gate[k], k, w);
      end
      if (e == 9) begin
        checks++;
        if ({st, wrap} !== {8'h01, 1'b1}) begin
          errors++;
          $display("FAIL basic_first_wrap got st=%h wrap=%b want st=01 wrap=1", st, wrap);
        end
      end
      tick();
    end
    en = 1'b0; tick();
  endtask

  task automatic test_random_run;
    int k;
    bit w;
    int n;
    int lap;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 16 : int'($urandom_range(1, 16));
      for (int j = 0; j < DEPTH; j++) do_write(j, 8'($urandom), int'($urandom_range(0, 5)));
      len = 5'(n); en = 1'b1; admin = 8'($urandom);
      tick(); tick();
      checks++;
      if ({st, running} !== {admin, 1'b0}) begin
        errors++;
        $display("FAIL rand_wait_admin got st=%h run=%b want st=%h run=0", st, running, admin);
      end
      lap = 0;
      for (int j = 0; j < n; j++) lap += dur(j);
      start = 1'b1; tick(); start = 1'b0;
      for (int e = 0; e < 2 * lap + 3; e++) begin
        ref_pos(e, n, k, w);
        checks++;
        if ({st, idx, wrap, running} !== {m_gate[k], 4'(k), w, 1'b1}) begin
          errors++;
          $display("FAIL rand_run len=%0d e=%0d got st=%h idx=%0d wrap=%b run=%b want st=%h idx=%0d wrap=%b",
                   n, e, st, idx, wrap, running, m_gate[k], k, w);
        end
        tick();
      end
      en = 1'b0; tick();
    end
  endtask

  task automatic test_zero_interval;
    logic [7:0] exp_g [4];
    do_write(0, 8'h11, 2);
    do_write(1, 8'h22, 0);
    do_write(2, 8'h33, 3);
    exp_g[0] = 8'h11; exp_g[1] = 8'h11; exp_g[2] = 8'h22; exp_g[3] = 8'h33;
    len = 5'd3; en = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (st !== exp_g[e]) begin
        errors++;
        $display("FAIL zero_intv e=%0d got %h want %h", e, st, exp_g[e]);
      end
      tick();
    end
    do_write(1, 8'h22, 4);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    // Entry 1 now showing with cycles left: resync mid-entry.
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({st, idx, wrap} !== {8'h11, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_start got st=%h idx=%0d wrap=%b want st=11 idx=0 wrap=0", st, idx, wrap);
    end
    tick(); tick();
    checks++;
    if ({st, idx} !== {8'h22, 4'd1}) begin
      errors++;
      $display("FAIL mid_start_resume got st=%h idx=%0d want st=22 idx=1", st, idx);
    end
    en = 1'b0; tick();
  endtask

  task automatic test_same_cycle;
    do_write(0, 8'h0A, 2);
    do_write(1, 8'h0B, 3);
    len = 5'd2; en = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    checks++;
    if ({st, idx} !== {8'h0B, 4'd1}) begin
      errors++;
      $display("FAIL same_cycle_pre got st=%h idx=%0d want st=0b idx=1", st, idx);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({st, idx, wrap} !== {8'h0A, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL same_cycle_start got st=%h idx=%0d wrap=%b want st=0a idx=0 wrap=0", st, idx, wrap);
    end
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if ({st, wrap} !== {8'h0A, 1'b1}) begin
      errors++;
      $display("FAIL same_cycle_next_wrap got st=%h wrap=%b want st=0a wrap=1", st, wrap);
    end
    en = 1'b0; tick();
  endtask

  task automatic test_write_collision;
    logic [7:0] exp_g [14];
    do_write(0, 8'h01, 2);
    do_write(1, 8'h02, 2);
    do_write(2, 8'h03, 2);
    len = 5'd3; en = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    // Write lands on the same edge that loads entry 1.
    wr_en = 1'b1; wr_addr = 4'd1; wr_gate = 8'h55; wr_intv = 32'd4;
    tick();
    wr_en = 1'b0;
    m_gate[1] = 8'h55; m_intv[1] = 4;
    for (int e = 2; e < 14; e++) exp_g[e] = 8'h03;
    exp_g[2] = 8'h02; exp_g[3] = 8'h02;
    exp_g[6] = 8'h01; exp_g[7] = 8'h01;
    for (int e = 8; e < 12; e++) exp_g[e] = 8'h55;
    for (int e = 2; e < 14; e++) begin
      checks++;
      if (st !== exp_g[e]) begin
        errors++;
        $display("FAIL write_collision e=%0d got %h want %h", e, st, exp_g[e]);
      end
      tick();
    end
    en = 1'b0; tick();
  endtask

  task automatic test_invalid_len;
    admin = 8'hC3; len = 5'd0; en = 1'b1;
    tick(); tick();
    checks++;
    if ({cfg_err, running, st} !== {1'b1, 1'b0, 8'hC3}) begin
      errors++;
      $display("FAIL len0_wait got err=%b run=%b st=%h want err=1 run=0 st=c3", cfg_err, running, st);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL len0_start got run=%b want 0", running);
    end
    len = 5'd4; tick();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({running, cfg_err, st} !== {1'b1, 1'b0, m_gate[0]}) begin
      errors++;
      $display("FAIL len4_run got run=%b err=%b st=%h want run=1 err=0 st=%h", running, cfg_err, st, m_gate[0]);
    end
    tick(); tick();
    len = 5'd17; tick();
    checks++;
    if ({running, cfg_err, st} !== {1'b0, 1'b1, 8'hC3}) begin
      errors++;
      $display("FAIL len17_exit got run=%b err=%b st=%h want run=0 err=1 st=c3", running, cfg_err, st);
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (running !== 1'b0) begin
      errors++;
      $display("FAIL len17_start got run=%b want 0", running);
    end
    en = 1'b0; len = 5'd3; tick();
  endtask

  task automatic test_disable_and_reset;
    len = 5'd3; en = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    admin = 8'h5A; en = 1'b0; tick();
    checks++;
    if ({running, st} !== {1'b0, 8'h5A}) begin
      errors++;
      $display("FAIL disable got run=%b st=%h want run=0 st=5a", running, st);
    end
    en = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick();
    checks++;
    if ({st, idx, running, wrap, cfg_err} !== {8'hFF, 4'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid_run got st=%h idx=%0d run=%b wrap=%b err=%b want st=ff idx=0 run=0 wrap=0 err=0",
               st, idx, running, wrap, cfg_err);
    end
    rst = 1'b0; en = 1'b0; tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_run();
    test_random_run();
    test_zero_interval();
    test_same_cycle();
    test_write_collision();
    test_invalid_len();
    test_disable_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
